// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard.
// Optional feature macro: SCOREBOARD_FWD_EN (see hazard_scoreboard.sv).
// Handshake: there is no valid/ready pair on this bundle. issue_valid offers
// one instruction per cycle. It is accepted in that same cycle exactly when
// issued=1. When stall=1 the decode stage must hold every issue field stable
// into the next cycle. flush withdraws the offer for the current cycle.
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int CW = 4
);
    logic          issue_valid;
    logic          issue_wr;
    logic [AW-1:0] issue_rd;
    logic [CW-1:0] issue_lat;
    logic          use_rs;
    logic          use_rt;
    logic [AW-1:0] src_rs;
    logic [AW-1:0] src_rt;
    logic          flush;
    logic          stall;
    logic          issued;
    logic          wb_valid;
    logic [AW-1:0] wb_reg;
    logic [AW:0]   pending_cnt;
    logic          fwd_a;
    logic          fwd_b;

    // Decode stage side
    modport master (
        output issue_valid, issue_wr, issue_rd, issue_lat,
        output use_rs, use_rt, src_rs, src_rt, flush,
        input  stall, issued, wb_valid, wb_reg, pending_cnt, fwd_a, fwd_b
    );

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_wr, issue_rd, issue_lat,
        input  use_rs, use_rt, src_rs, src_rt, flush,
        output stall, issued, wb_valid, wb_reg, pending_cnt, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Variable-latency hazard scoreboard.
// Per-register countdowns track in-flight writes, and a writeback slot shift
// register reserves the single writeback port. Slot k holds the write that
// retires k cycles from now, so slot 1 is the write retiring this cycle.
// Optional macro SCOREBOARD_FWD_EN: a source whose countdown is 1 is on the
// writeback bus this cycle. It is forwarded (fwd_a/fwd_b) instead of stalling.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int MAXLAT = 8,
    parameter int CW     = 4
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    // Entry 0 is never loaded, so r0 always reads as not pending.
    logic [CW-1:0] cnt     [NREG];
    logic [CW-1:0] cnt_nxt [NREG];
    logic [MAXLAT:1] slot_v, slot_v_nxt;
    logic [AW-1:0] slot_r     [1:MAXLAT];
    logic [AW-1:0] slot_r_nxt [1:MAXLAT];
    logic [AW:0]   pend, pend_nxt;

    logic [CW-1:0] lat_eff;
    logic [CW-1:0] cnt_rs, cnt_rt, cnt_rd;
    logic          raw_rs, raw_rt, waw, port_busy, hazard, track;
    logic          fwd_rs, fwd_rt;

    // Clamp the requested latency into 1..MAXLAT
    always_comb begin
        lat_eff = sb.issue_lat;
        if (sb.issue_lat == '0)
            lat_eff = CW'(1);
        else if (sb.issue_lat > CW'(MAXLAT))
            lat_eff = CW'(MAXLAT);
    end

    // Hazard detection against the current countdowns and slot reservations
    always_comb begin
        cnt_rs = cnt[sb.src_rs];
        cnt_rt = cnt[sb.src_rt];
        cnt_rd = cnt[sb.issue_rd];
`ifdef SCOREBOARD_FWD_EN
        raw_rs = sb.use_rs && (sb.src_rs != '0) && (cnt_rs > CW'(1));
        raw_rt = sb.use_rt && (sb.src_rt != '0) && (cnt_rt > CW'(1));
        fwd_rs = sb.issue_valid && sb.use_rs && (sb.src_rs != '0) && (cnt_rs == CW'(1));
        fwd_rt = sb.issue_valid && sb.use_rt && (sb.src_rt != '0) && (cnt_rt == CW'(1));
`else
        raw_rs = sb.use_rs && (sb.src_rs != '0) && (cnt_rs != '0);
        raw_rt = sb.use_rt && (sb.src_rt != '0) && (cnt_rt != '0);
        fwd_rs = 1'b0;
        fwd_rt = 1'b0;
`endif
        waw = sb.issue_wr && (sb.issue_rd != '0) && (cnt_rd > lat_eff);
        // Slot L after this edge's shift is slot L+1 now; nothing sits beyond MAXLAT.
        port_busy = 1'b0;
        for (int k = 1; k < MAXLAT; k++)
            if (lat_eff == CW'(k))
                port_busy = slot_v[k+1];
        port_busy = port_busy && sb.issue_wr && (sb.issue_rd != '0);
        hazard = raw_rs || raw_rt || waw || port_busy;
    end

    assign sb.stall    = sb.issue_valid && !sb.flush && hazard;
    assign sb.issued   = sb.issue_valid && !sb.flush && !hazard;
    assign sb.fwd_a    = fwd_rs;
    assign sb.fwd_b    = fwd_rt;
    assign sb.wb_valid = slot_v[1];
    assign sb.wb_reg   = slot_r[1];
    assign sb.pending_cnt = pend;

    assign track = sb.issued && sb.issue_wr && (sb.issue_rd != '0);

    // Next state: countdowns decrement, slots shift, an accepted write reloads its entries
    always_comb begin
        for (int r = 0; r < NREG; r++)
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
        for (int k = 1; k < MAXLAT; k++) begin
            slot_v_nxt[k] = slot_v[k+1];
            slot_r_nxt[k] = slot_r[k+1];
        end
        slot_v_nxt[MAXLAT] = 1'b0;
        slot_r_nxt[MAXLAT] = '0;
        if (track) begin
            cnt_nxt[sb.issue_rd] = lat_eff;
            for (int k = 1; k <= MAXLAT; k++) begin
                if (lat_eff == CW'(k)) begin
                    slot_v_nxt[k] = 1'b1;
                    slot_r_nxt[k] = sb.issue_rd;
                end
            end
        end
        pend_nxt = '0;
        for (int r = 1; r < NREG; r++)
            if (cnt_nxt[r] != '0)
                pend_nxt = pend_nxt + (AW+1)'(1);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            for (int k = 1; k <= MAXLAT; k++)
                slot_r[k] <= '0;
            slot_v <= '0;
            pend   <= '0;
        end else begin
            cnt    <= cnt_nxt;
            slot_v <= slot_v_nxt;
            slot_r <= slot_r_nxt;
            pend   <= pend_nxt;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The reference model keeps, for each register,
// the absolute cycle in which its latest write retires, plus a map of
// reserved writeback cycles. Every output is derived from those each cycle.
module tb_hazard_scoreboard;
    localparam int NREG = 32, AW = 5, MAXLAT = 8, CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW), .CW(CW)) sbif ();

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ret [NREG];        // cycle in which the register's last write retires
    int sched [int];       // writeback cycle -> register
    int wb_count [NREG];   // observed retirements per register
    int max_pend = 0;
    bit cap = 1'b0;
    logic [AW-1:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rem(input int r, input int c);
        if (r == 0 || ret[r] < c) return 0;
        return ret[r] - c + 1;
    endfunction

    function automatic int eff_lat(input int l);
        if (l == 0) return 1;
        if (l > MAXLAT) return MAXLAT;
        return l;
    endfunction

    // Compare process: mid-cycle, after inputs have settled
    always @(negedge clk) begin
        #2;
        if (reset) begin
            for (int r = 0; r < NREG; r++) ret[r] = -1;
            sched.delete();
            check("rst_wb_valid", int'(sbif.wb_valid), 0);
            check("rst_wb_reg", int'(sbif.wb_reg), 0);
            check("rst_pending", int'(sbif.pending_cnt), 0);
            check("rst_stall", int'(sbif.stall), 0);
            check("rst_fwd", int'({sbif.fwd_a, sbif.fwd_b}), 0);
        end else begin
            int l, rs, rt, rd, pend, e_wbv, e_wbr;
            bit raw, waw, port, haz, e_stall, e_iss, e_fa, e_fb;
            l  = eff_lat(int'(sbif.issue_lat));
            rs = int'(sbif.src_rs);
            rt = int'(sbif.src_rt);
            rd = int'(sbif.issue_rd);
`ifdef SCOREBOARD_FWD_EN
            raw = (sbif.use_rs && rem(rs, cyc) > 1) || (sbif.use_rt && rem(rt, cyc) > 1);
            e_fa = sbif.issue_valid && sbif.use_rs && rem(rs, cyc) == 1;
            e_fb = sbif.issue_valid && sbif.use_rt && rem(rt, cyc) == 1;
`else
            raw = (sbif.use_rs && rem(rs, cyc) > 0) || (sbif.use_rt && rem(rt, cyc) > 0);
            e_fa = 1'b0;
            e_fb = 1'b0;
`endif
            waw  = sbif.issue_wr && rd != 0 && rem(rd, cyc) > l;
            port = sbif.issue_wr && rd != 0 && sched.exists(cyc + l);
            haz  = raw || waw || port;
            e_stall = sbif.issue_valid && !sbif.flush && haz;
            e_iss   = sbif.issue_valid && !sbif.flush && !haz;
            pend = 0;
            for (int r = 1; r < NREG; r++) if (ret[r] >= cyc) pend++;
            e_wbv = sched.exists(cyc) ? 1 : 0;
            e_wbr = sched.exists(cyc) ? sched[cyc] : 0;

            check("stall", int'(sbif.stall), int'(e_stall));
            check("issued", int'(sbif.issued), int'(e_iss));
            check("wb_valid", int'(sbif.wb_valid), e_wbv);
            check("wb_reg", int'(sbif.wb_reg), e_wbr);
            check("pending_cnt", int'(sbif.pending_cnt), pend);
            check("fwd_a", int'(sbif.fwd_a), int'(e_fa));
            check("fwd_b", int'(sbif.fwd_b), int'(e_fb));

            if (sbif.wb_valid) begin
                wb_count[sbif.wb_reg]++;
                if (cap) begin
                    if (exp_q.size() == 0) check("wb_order_extra", int'(sbif.wb_reg), -1);
                    else check("wb_order", int'(sbif.wb_reg), int'(exp_q.pop_front()));
                end
            end
            if (int'(sbif.pending_cnt) > max_pend) max_pend = int'(sbif.pending_cnt);

            if (e_iss && sbif.issue_wr && rd != 0) begin
                ret[rd] = cyc + l;
                sched[cyc + l] = rd;
            end
            if (sched.exists(cyc)) sched.delete(cyc);
        end
        cyc++;
    end

    task automatic drive(input bit v, input bit wr, input int rd, input int lat,
                         input bit urs, input int rs, input bit urt, input int rt,
                         input bit fl);
        @(negedge clk);
        sbif.issue_valid = v;
        sbif.issue_wr    = wr;
        sbif.issue_rd    = AW'(rd);
        sbif.issue_lat   = CW'(lat);
        sbif.use_rs      = urs;
        sbif.src_rs      = AW'(rs);
        sbif.use_rt      = urt;
        sbif.src_rt      = AW'(rt);
        sbif.flush       = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Offer an instruction and hold it until accepted; returns stall cycles seen
    task automatic issue_hold(input bit wr, input int rd, input int lat,
                              input bit urs, input int rs, input bit urt, input int rt,
                              output int stalls, output bit fa);
        drive(1, wr, rd, lat, urs, rs, urt, rt, 0);
        #3;
        stalls = 0;
        while (!sbif.issued && stalls < 20) begin
            stalls++;
            drive(1, wr, rd, lat, urs, rs, urt, rt, 0);
            #3;
        end
        fa = sbif.fwd_a;
        if (stalls >= 20) check("issue_timeout", 1, 0);
    endtask

    // Cycles from now until the next writeback pulse
    task automatic wait_wb(output int d, output int r);
        d = 0;
        r = -1;
        while (d < 20) begin
            idle(1);
            d++;
            #3;
            if (sbif.wb_valid) begin
                r = int'(sbif.wb_reg);
                break;
            end
        end
        if (d >= 20) check("wb_timeout", 1, 0);
    endtask

    initial begin
        int st, d, r, n5, n7;
        bit fa;
        reset = 1'b1;
        sbif.issue_valid = 0; sbif.issue_wr = 0; sbif.issue_rd = '0; sbif.issue_lat = '0;
        sbif.use_rs = 0; sbif.use_rt = 0; sbif.src_rs = '0; sbif.src_rt = '0; sbif.flush = 0;
        idle(2);
        @(negedge clk); reset = 1'b0;
        idle(2);

        // Reset in flight: r5 must never retire
        n5 = wb_count[5];
        issue_hold(1, 5, 4, 0, 0, 0, 0, st, fa);
        idle(2);
        @(negedge clk); reset = 1'b1;
        idle(1);
        @(negedge clk); reset = 1'b0;
        idle(10);
        check("reset_no_r5_wb", wb_count[5] - n5, 0);

        // RAW on r3 written with latency 3
        issue_hold(1, 3, 3, 0, 0, 0, 0, st, fa);
        issue_hold(0, 0, 0, 1, 3, 0, 0, st, fa);
`ifdef SCOREBOARD_FWD_EN
        check("raw_stalls", st, 2);
        check("raw_fwd_a", int'(fa), 1);
`else
        check("raw_stalls", st, 3);
        check("raw_fwd_a", int'(fa), 0);
`endif
        idle(10);

        // WAW on r7: long write then short write; two retirements in order
        n7 = wb_count[7];
        exp_q.push_back(AW'(7)); exp_q.push_back(AW'(7));
        cap = 1'b1;
        issue_hold(1, 7, 6, 0, 0, 0, 0, st, fa);
        issue_hold(1, 7, 1, 0, 0, 0, 0, st, fa);
        check("waw_stalls", st, 5);
        idle(10);
        check("waw_r7_pulses", wb_count[7] - n7, 2);
        check("waw_queue_empty", exp_q.size(), 0);

        // Writeback port conflict: r4 then r9
        exp_q.push_back(AW'(4)); exp_q.push_back(AW'(9));
        issue_hold(1, 4, 3, 0, 0, 0, 0, st, fa);
        issue_hold(1, 9, 2, 0, 0, 0, 0, st, fa);
        check("port_stalls", st, 1);
        wait_wb(d, r);
        check("port_first_reg", r, 4);
        wait_wb(d, r);
        check("port_gap", d, 1);
        check("port_second_reg", r, 9);
        idle(8);
        check("port_queue_empty", exp_q.size(), 0);
        cap = 1'b0;

        // r0 write is untracked
        issue_hold(1, 0, 5, 0, 0, 0, 0, st, fa);
        idle(1); #3;
        check("r0_pending", int'(sbif.pending_cnt), 0);
        idle(8);

        // Latency clamps
        issue_hold(1, 10, 0, 0, 0, 0, 0, st, fa);
        wait_wb(d, r);
        check("lat0_delay", d, 1);
        check("lat0_reg", r, 10);
        idle(3);
        issue_hold(1, 11, 15, 0, 0, 0, 0, st, fa);
        wait_wb(d, r);
        check("lat15_delay", d, 8);
        check("lat15_reg", r, 11);
        idle(3);

        // Flushed offer changes nothing
        drive(1, 1, 12, 2, 0, 0, 0, 0, 1);
        #3;
        check("flush_issued", int'(sbif.issued), 0);
        check("flush_stall", int'(sbif.stall), 0);
        idle(1); #3;
        check("flush_pending", int'(sbif.pending_cnt), 0);
        idle(4);

        // Eight back-to-back writes, then read r8
        max_pend = 0;
        for (int k = 1; k <= 8; k++) issue_hold(1, k, 8, 0, 0, 0, 0, st, fa);
        issue_hold(0, 0, 0, 1, 8, 0, 0, st, fa);
        check("pend_peak", max_pend, 8);
`ifdef SCOREBOARD_FWD_EN
        check("pend_read_stalls", st, 7);
`else
        check("pend_read_stalls", st, 8);
`endif
        idle(12);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(1, 0), $urandom_range(7, 0),
                  $urandom_range(15, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                  $urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(15, 0) == 0);
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
